lsu: RTL and testbench
======================

// Module: lsu
// PURPOSE
//  Memory stage: consumes ex_lsu_t from EXU and produces lsu_wb_t for WBU.
//  Issues load/store requests on a valid/ready data-memory port, aligns/extends load data, passes non-memory ops through.
//  One operation in flight; in-order; sits between EXU and WBU.
// PARAMETERS
//  XLEN  32  data/address width; only 32 is supported
// PORTS
//  clk            in   1         single clock
//  rst_n          in   1         synchronous reset, active-low
//  in_valid       in   1         EXU payload valid
//  in_ready       out  1         LSU can accept a payload
//  in_data        in   ex_lsu_t  EXU->LSU payload; .valid field ignored
//  out_valid      out  1         WBU payload valid
//  out_ready      in   1         WBU accepts payload
//  out_data       out  lsu_wb_t  LSU->WBU payload; .valid mirrors out_valid
//  mem_req_valid  out  1         memory request valid
//  mem_req_ready  in   1         memory accepts request
//  mem_req_addr   out  32        word-aligned address {mem_addr[31:2],2'b00}
//  mem_req_wen    out  1         1 = store, 0 = load
//  mem_req_wdata  out  32        store data, lane-replicated
//  mem_req_wstrb  out  4         byte strobes; 4'b0000 for loads
//  mem_rsp_valid  in   1         response valid; at least 1 cycle after request fire
//  mem_rsp_rdata  in   32        load data (full aligned word)
//  misalign       out  1         only with LSU_ALIGN_CHECK_EN; see CONFIGURATION
// BEHAVIOUR
//  - FSM: S_IDLE, S_REQ, S_RESP, S_OUT. Reset (rst_n=0 at posedge): state=S_IDLE; latched payload=0; every output 0 except in_ready=1.
//  - Reset mid-transaction abandons the operation; memory shares the reset.
//  - S_IDLE: in_ready=1. On in_valid, latch in_data. mem_en=0 -> S_OUT; mem_en=1 -> S_REQ.
//  - S_REQ: mem_req_valid=1, addr/wen/wdata/wstrb stable until mem_req_ready. Fire -> S_RESP.
//  - S_RESP: wait for mem_rsp_valid; mem_rsp_valid in any other state is ignored.
//    - Load: wb_data = formatted rdata.
//    - Store: wb_data = exu_result.
//    - Then -> S_OUT.
//  - S_OUT: out_valid=1; out_data held stable until out_ready. Fire -> S_IDLE.
//  - in_ready=0 outside S_IDLE; no accept in the S_OUT-fire cycle.
//  - Latency (accept edge to out_valid):
//    - pass-through: 1 cycle.
//    - memory op with zero-wait memory and rsp one cycle after fire: 3 cycles.
//  - Pass-through: wb_data=exu_result. rd_addr/reg_wen/pc_target always copied from the latched payload.
//  - Store encoding: off=mem_addr[1:0].
//    - funct3[1:0]=00 SB: wstrb=4'b0001<<off, wdata={4{wdata[7:0]}}
//    - 01 SH: wstrb=4'b0011<<{off[1],1'b0}, wdata={2{wdata[15:0]}}
//    - 10/11 SW: wstrb=4'b1111, wdata unchanged
//  - Load format: uses the latched off.
//    - 000 LB and 100 LBU: byte rdata[8*off+:8], LB sign-extended, LBU zero-extended.
//    - 001 LH and 101 LHU: half rdata[16*off[1]+:16], LH sign-extended, LHU zero-extended.
//    - 010 and all other funct3 values: LW, full word.
//  - off[0] ignored for halfwords; off ignored for words (truncation), unless LSU_ALIGN_CHECK_EN.
// CONFIGURATION
//  LSU_ALIGN_CHECK_EN defined:
//   - Misaligned = H with off[0]=1, or W with off!=0.
//   - Misaligned mem op skips S_REQ/S_RESP and goes S_IDLE -> S_OUT. No memory request is issued.
//   - out_data.reg_wen forced 0; misalign=1 while in S_OUT; 0 otherwise and after reset.
//  LSU_ALIGN_CHECK_EN undefined: misalign port absent; truncation rules above apply.
// STRUCTURE
//  cpu_types_pkg gains:
//   - lsu_state_e {S_IDLE,S_REQ,S_RESP,S_OUT}
//   - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101
//  One sub-module: lsu_load_fmt, combinational. Inputs rdata[31:0], off[1:0], funct3[2:0]; output wb_data[31:0].
//  Store encoding stays inline.
// TESTING
//  1 Pass-through: mem_en=0, exu_result=0x1234, rd=5, reg_wen=1, out_ready=1 -> out_valid 1 cycle after accept, wb_data=0x1234, no mem_req_valid.
//  2 LB/LBU: addr=0x8000_0003, rdata=0x80FF_0000. LB -> 0xFFFF_FF80; LBU -> 0x0000_0080. mem_req_addr=0x8000_0000, wstrb=0.
//  3 SH: addr=0x100_0002, wdata=0xAAAA_BEEF -> wstrb=4'b1100, wdata=0xBEEF_BEEF, wen=1. mem_req_ready low 3 cycles -> request held stable.
//  4 Backpressure: out_ready=0 for 4 cycles -> out_data stable, in_ready=0. Release -> in_ready=1 the following cycle.
//  5 Reset: rst_n=0 while in S_RESP -> next cycle S_IDLE, out_valid=0, mem_req_valid=0. A later mem_rsp_valid is ignored.
//  6 LSU_ALIGN_CHECK_EN: LW at 0x1002 -> no mem_req_valid; out_valid with reg_wen=0 and misalign=1. Without the macro: mem_req_addr=0x1000, LW returns rdata.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types used by the memory stage: stage payload structs,
// load/store funct3 encodings, the LSU state enum and access-size helpers.
package cpu_types_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_OUT
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    // EXU -> LSU payload
    typedef struct packed {
        logic        valid;
        logic [31:0] pc_target;
        logic [31:0] exu_result;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic        mem_en;
        logic        mem_wen;
        logic [2:0]  funct3;
        logic [4:0]  rd_addr;
        logic        reg_wen;
    } ex_lsu_t;

    // LSU -> WBU payload
    typedef struct packed {
        logic        valid;
        logic [31:0] wb_data;
        logic [4:0]  rd_addr;
        logic        reg_wen;
        logic [31:0] pc_target;
    } lsu_wb_t;

    // Access size is carried in funct3[1:0] for both loads and stores;
    // funct3[2] only selects zero-extension on loads.
    function automatic mem_size_e mem_size(input logic [2:0] funct3);
        mem_size_e sz;
        case (funct3[1:0])
            2'b00:   sz = SZ_BYTE;
            2'b01:   sz = SZ_HALF;
            default: sz = SZ_WORD;
        endcase
        return sz;
    endfunction

    // Halfwords need an even offset, words need offset zero; bytes never fault.
    function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic bad;
        case (mem_size(funct3))
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load data formatter: selects the addressed byte/halfword out of the aligned
// memory word and sign- or zero-extends it. Purely combinational.
module lsu_load_fmt
    import cpu_types_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] wb_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select then extension; off[0] is ignored for halfwords.
    always_comb begin
        byte_sel = rdata[{off, 3'b000} +: 8];
        half_sel = rdata[{off[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    wb_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   wb_data = {24'h000000, byte_sel};
            F3_H:    wb_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   wb_data = {16'h0000, half_sel};
            default: wb_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Memory stage between EXU and WBU. Accepts one payload at a time, issues a
// load/store on the valid/ready data-memory port, formats load data and
// passes non-memory ops straight through.
// Optional build macro: LSU_ALIGN_CHECK_EN adds the misalign output and
// turns misaligned half/word accesses into non-writing, memory-free ops.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | ready for a new payload (in_ready=1)
//  S_REQ  | memory request presented, waiting for mem_req_ready
//  S_RESP | request accepted, waiting for mem_rsp_valid
//  S_OUT  | result presented to WBU, waiting for out_ready
module lsu
    import cpu_types_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  ex_lsu_t         in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output lsu_wb_t         out_data,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    output logic            mem_req_wen,
    output logic [XLEN-1:0] mem_req_wdata,
    output logic [3:0]      mem_req_wstrb,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_rdata
`ifdef LSU_ALIGN_CHECK_EN
    ,
    output logic            misalign
`endif
);

    lsu_state_e  state_q, state_d;
    ex_lsu_t     pl_q, pl_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic [1:0]  off;
    logic [31:0] load_wb;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic        in_mis;
    logic        cur_mis;
    logic        unused_pl;

    assign off = pl_q.mem_addr[1:0];

`ifdef LSU_ALIGN_CHECK_EN
    assign in_mis  = in_data.mem_en & lsu_misaligned(in_data.funct3, in_data.mem_addr[1:0]);
    assign cur_mis = pl_q.mem_en & lsu_misaligned(pl_q.funct3, off);
`else
    assign in_mis  = 1'b0;
    assign cur_mis = 1'b0;
`endif

    // The valid bit of the latched payload carries no meaning after accept.
    assign unused_pl = pl_q.valid;

    lsu_load_fmt u_load_fmt (
        .rdata   (mem_rsp_rdata),
        .off     (off),
        .funct3  (pl_q.funct3),
        .wb_data (load_wb)
    );

    // Store lane encoding: replicate the data into every lane, strobe the target.
    always_comb begin
        st_wstrb = 4'b0000;
        st_wdata = pl_q.mem_wdata;
        case (mem_size(pl_q.funct3))
            SZ_BYTE: begin
                st_wstrb = 4'b0001 << off;
                st_wdata = {4{pl_q.mem_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_wstrb = 4'b0011 << {off[1], 1'b0};
                st_wdata = {2{pl_q.mem_wdata[15:0]}};
            end
            default: begin
                st_wstrb = 4'b1111;
            end
        endcase
        if (!pl_q.mem_wen) begin
            st_wstrb = 4'b0000;
        end
    end

    // Next-state, payload capture and write-back data selection.
    always_comb begin
        state_d   = state_q;
        pl_d      = pl_q;
        wb_data_d = wb_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    pl_d       = in_data;
                    pl_d.valid = 1'b0;
                    if (!in_data.mem_en || in_mis) begin
                        wb_data_d = in_data.exu_result;
                        state_d   = S_OUT;
                    end else begin
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (mem_rsp_valid) begin
                    wb_data_d = pl_q.mem_wen ? pl_q.exu_result : load_wb;
                    state_d   = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and payload registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pl_q      <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            pl_q      <= pl_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_OUT);
    assign mem_req_valid = (state_q == S_REQ) & pl_q.mem_en;
    assign mem_req_addr  = {pl_q.mem_addr[31:2], 2'b00};
    assign mem_req_wen   = pl_q.mem_wen;
    assign mem_req_wdata = st_wdata;
    assign mem_req_wstrb = st_wstrb;

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign = (state_q == S_OUT) & cur_mis;
`endif

    // WBU payload is a direct view of the latched operation and its result.
    always_comb begin
        out_data           = '0;
        out_data.valid     = out_valid;
        out_data.wb_data   = wb_data_q;
        out_data.rd_addr   = pl_q.rd_addr;
        out_data.reg_wen   = pl_q.reg_wen & ~cur_mis;
        out_data.pc_target = pl_q.pc_target;
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: expected write-back payloads are queued when an
// operation is driven and popped when the DUT presents its result.
module tb_lsu;
    import cpu_types_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    ex_lsu_t     in_data;
    logic        out_valid;
    logic        out_ready;
    lsu_wb_t     out_data;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = 32'h0;
`ifdef LSU_ALIGN_CHECK_EN
    logic        misalign;
`endif

    lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata)
`ifdef LSU_ALIGN_CHECK_EN
        ,
        .misalign      (misalign)
`endif
    );

    int          n_checks;
    int          n_fails;
    lsu_wb_t     exp_q[$];

    // memory model knobs, written only by the stimulus process
    int          mem_stall;
    int          mem_rsp_delay;
    logic [31:0] mem_word;

    // memory model state, owned by the responder
    int          req_seen   = 0;
    int          stall_cnt  = 0;
    int          rsp_cnt    = 0;
    logic        fire_armed = 1'b0;

    // Memory responder: holds ready low mem_stall cycles per request and
    // answers mem_rsp_delay cycles after the request handshake.
    always @(negedge clk) begin
        if (fire_armed) rsp_cnt = mem_rsp_delay;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = $urandom;
        if (rsp_cnt > 0) begin
            rsp_cnt = rsp_cnt - 1;
            if (rsp_cnt == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = mem_word;
            end
        end
        if (mem_req_valid) begin
            req_seen = req_seen + 1;
            if (stall_cnt < mem_stall) begin
                mem_req_ready = 1'b0;
                stall_cnt     = stall_cnt + 1;
            end else begin
                mem_req_ready = 1'b1;
            end
        end else begin
            mem_req_ready = 1'b0;
            stall_cnt     = 0;
        end
        fire_armed = mem_req_valid && mem_req_ready && rst_n;
    end

    function automatic ex_lsu_t mk_op(input logic mem_en, input logic [31:0] res,
                                      input logic [31:0] addr, input logic [31:0] wd,
                                      input logic [2:0] f3, input logic wen,
                                      input logic [4:0] rd, input logic rwen,
                                      input logic [31:0] pc);
        ex_lsu_t p;
        p            = '0;
        p.valid      = 1'b1;
        p.pc_target  = pc;
        p.exu_result = res;
        p.mem_addr   = addr;
        p.mem_wdata  = wd;
        p.mem_en     = mem_en;
        p.mem_wen    = wen;
        p.funct3     = f3;
        p.rd_addr    = rd;
        p.reg_wen    = rwen;
        return p;
    endfunction

    function automatic lsu_wb_t mk_wb(input logic [31:0] d, input logic [4:0] rd,
                                      input logic rwen, input logic [31:0] pc);
        lsu_wb_t w;
        w.valid     = 1'b1;
        w.wb_data   = d;
        w.rd_addr   = rd;
        w.reg_wen   = rwen;
        w.pc_target = pc;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = w >> (8 * int'(off));
        h = w >> (16 * int'(off[1]));
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'h0, h[15:0]};
            default: return w;
        endcase
    endfunction

`ifdef LSU_ALIGN_CHECK_EN
    function automatic logic tb_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (f3[1:0] == 2'b01) return off[0];
        if (f3[1:0] != 2'b00) return off != 2'b00;
        return 1'b0;
    endfunction
`endif

    // Presents p at the current negedge once in_ready, returns one negedge after accept.
    task automatic drive_in(input ex_lsu_t p, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            in_data  = p;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            ok       = 1'b1;
        end
    endtask

    // Counts negedges (starting at 1) until out_valid; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (mem_req_valid !== 1'b0) begin
            n_fails++; $display("FAIL reset_mem_req_valid: got %b expected 0", mem_req_valid);
        end
        n_checks++;
        if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb} !== 69'h0) begin
            n_fails++; $display("FAIL reset_mem_req_fields: got %h/%b/%h/%b expected all 0",
                                mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb);
        end
        n_checks++;
        if (out_data !== '0) begin
            n_fails++; $display("FAIL reset_out_data: got %h expected 0", out_data);
        end
`ifdef LSU_ALIGN_CHECK_EN
        n_checks++;
        if (misalign !== 1'b0) begin
            n_fails++; $display("FAIL reset_misalign: got %b expected 0", misalign);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthrough();
        int      seen0;
        int      lat;
        bit      ok;
        lsu_wb_t e;
        seen0 = req_seen;
        exp_q.push_back(mk_wb(32'h0000_1234, 5'd5, 1'b1, 32'h0000_0040));
        drive_in(mk_op(1'b0, 32'h0000_1234, 32'h0000_0000, 32'h0, F3_W, 1'b0, 5'd5, 1'b1,
                       32'h0000_0040), ok);
        wait_out(lat);
        n_checks++;
        if (!ok || lat != 1) begin
            n_fails++; $display("FAIL pass_latency: got %0d (accepted %b) expected 1", lat, ok);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (out_data !== e) begin
            n_fails++; $display("FAIL pass_out_data: got %h expected %h", out_data, e);
        end
        n_checks++;
        if (req_seen != seen0) begin
            n_fails++; $display("FAIL pass_no_mem_req: got %0d request cycles expected 0",
                                req_seen - seen0);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++; $display("FAIL pass_return_idle: got out_valid=%b in_ready=%b expected 0/1",
                                out_valid, in_ready);
        end
    endtask

    task automatic test_lb_lbu();
        int          lat;
        bit          ok;
        lsu_wb_t     e;
        logic [2:0]  f3;
        logic [31:0] expd;
        mem_word = 32'h80FF_0000;
        for (int i = 0; i < 2; i++) begin
            f3   = (i == 0) ? F3_B : F3_BU;
            expd = (i == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            exp_q.push_back(mk_wb(expd, 5'd7, 1'b1, 32'h0000_0100));
            drive_in(mk_op(1'b1, 32'hDEAD_0000, 32'h8000_0003, 32'h0, f3, 1'b0, 5'd7, 1'b1,
                           32'h0000_0100), ok);
            n_checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
                n_fails++; $display("FAIL lb_req_addr f3=%b: got valid=%b addr=%h expected 1/80000000",
                                    f3, mem_req_valid, mem_req_addr);
            end
            n_checks++;
            if (mem_req_wstrb !== 4'b0000 || mem_req_wen !== 1'b0) begin
                n_fails++; $display("FAIL lb_req_strb f3=%b: got wstrb=%b wen=%b expected 0000/0",
                                    f3, mem_req_wstrb, mem_req_wen);
            end
            wait_out(lat);
            n_checks++;
            if (!ok || lat != 3) begin
                n_fails++; $display("FAIL lb_latency f3=%b: got %0d expected 3", f3, lat);
            end
            e = exp_q.pop_front();
            n_checks++;
            if (out_data !== e) begin
                n_fails++; $display("FAIL lb_out_data f3=%b: got %h expected %h", f3, out_data, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store_sh();
        int          lat;
        bit          ok;
        lsu_wb_t     e;
        logic [68:0] snap;
        mem_stall = 3;
        exp_q.push_back(mk_wb(32'h0100_0002, 5'd0, 1'b0, 32'h0000_0200));
        drive_in(mk_op(1'b1, 32'h0100_0002, 32'h0100_0002, 32'hAAAA_BEEF, F3_H, 1'b1, 5'd0, 1'b0,
                       32'h0000_0200), ok);
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0100_0000 || mem_req_wen !== 1'b1) begin
            n_fails++; $display("FAIL sh_req: got valid=%b addr=%h wen=%b expected 1/01000000/1",
                                mem_req_valid, mem_req_addr, mem_req_wen);
        end
        n_checks++;
        if (mem_req_wstrb !== 4'b1100 || mem_req_wdata !== 32'hBEEF_BEEF) begin
            n_fails++; $display("FAIL sh_lanes: got wstrb=%b wdata=%h expected 1100/beefbeef",
                                mem_req_wstrb, mem_req_wdata);
        end
        snap = {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (mem_req_valid !== 1'b1 ||
                {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb} !== snap) begin
                n_fails++; $display("FAIL sh_hold cycle %0d: got valid=%b req=%h expected 1/%h", c,
                                    mem_req_valid,
                                    {mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb}, snap);
            end
        end
        wait_out(lat);
        n_checks++;
        if (!ok || lat != 3) begin
            n_fails++; $display("FAIL sh_latency_after_stall: got %0d expected 3", lat);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (out_data !== e) begin
            n_fails++; $display("FAIL sh_out_data: got %h expected %h", out_data, e);
        end
        mem_stall = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int      lat;
        bit      ok;
        lsu_wb_t e;
        out_ready = 1'b0;
        exp_q.push_back(mk_wb(32'hCAFE_0001, 5'd9, 1'b1, 32'h0000_0300));
        drive_in(mk_op(1'b0, 32'hCAFE_0001, 32'h0, 32'h0, F3_W, 1'b0, 5'd9, 1'b1,
                       32'h0000_0300), ok);
        wait_out(lat);
        e = exp_q.pop_front();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== e) begin
                n_fails++; $display("FAIL bp_hold cycle %0d: got valid=%b data=%h expected 1/%h", c,
                                    out_valid, out_data, e);
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fails++; $display("FAIL bp_in_ready cycle %0d: got %b expected 0", c, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_data   = mk_op(1'b0, 32'h5555_AAAA, 32'h0, 32'h0, F3_W, 1'b0, 5'd3, 1'b1, 32'h0000_0304);
        in_valid  = 1'b1;
        exp_q.push_back(mk_wb(32'h5555_AAAA, 5'd3, 1'b1, 32'h0000_0304));
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fails++; $display("FAIL bp_release: got in_ready=%b out_valid=%b expected 1/0",
                                in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            n_fails++; $display("FAIL b2b_out: got valid=%b data=%h expected 1/%h",
                                out_valid, out_data, e);
        end
        @(negedge clk);
    endtask

    task automatic test_load_matrix();
        logic [2:0]  f3s [5];
        logic [31:0] word;
        logic [31:0] addr;
        int          lat;
        bit          ok;
        lsu_wb_t     e;
        f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
        for (int i = 0; i < 5; i++) begin
            for (int o = 0; o < 4; o++) begin
`ifdef LSU_ALIGN_CHECK_EN
                if (tb_misaligned(f3s[i], o[1:0])) continue;
`endif
                word       = $urandom;
                addr       = $urandom;
                addr[1:0]  = o[1:0];
                mem_word   = word;
                exp_q.push_back(mk_wb(model_load(word, o[1:0], f3s[i]), 5'(i * 4 + o), 1'b1,
                                      addr ^ 32'h0F0F_0000));
                drive_in(mk_op(1'b1, 32'h0, addr, 32'h0, f3s[i], 1'b0, 5'(i * 4 + o), 1'b1,
                               addr ^ 32'h0F0F_0000), ok);
                n_checks++;
                if (mem_req_addr !== {addr[31:2], 2'b00} || mem_req_wstrb !== 4'b0000) begin
                    n_fails++; $display("FAIL ld_req f3=%b off=%0d: got addr=%h wstrb=%b expected %h/0000",
                                        f3s[i], o, mem_req_addr, mem_req_wstrb, {addr[31:2], 2'b00});
                end
                wait_out(lat);
                e = exp_q.pop_front();
                n_checks++;
                if (!ok || lat != 3 || out_data !== e) begin
                    n_fails++; $display("FAIL ld_data f3=%b off=%0d: got lat=%0d data=%h expected 3/%h",
                                        f3s[i], o, lat, out_data, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_store_matrix();
        logic [31:0] wd;
        logic [31:0] addr;
        logic [31:0] res;
        logic [31:0] exp_wd;
        logic [3:0]  exp_strb;
        logic [2:0]  f3;
        logic        rw;
        int          lat;
        bit          ok;
        lsu_wb_t     e;
        for (int i = 0; i < 4; i++) begin
            for (int o = 0; o < 4; o++) begin
                f3 = 3'(i);
`ifdef LSU_ALIGN_CHECK_EN
                if (tb_misaligned(f3, o[1:0])) continue;
`endif
                wd        = $urandom;
                res       = $urandom;
                addr      = $urandom;
                addr[1:0] = o[1:0];
                rw        = 1'($urandom_range(0, 1));
                exp_strb  = 4'b0000;
                if (i == 0) begin
                    exp_strb[o] = 1'b1;
                    exp_wd      = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
                end else if (i == 1) begin
                    exp_strb = addr[1] ? 4'b1100 : 4'b0011;
                    exp_wd   = {wd[15:0], wd[15:0]};
                end else begin
                    exp_strb = 4'b1111;
                    exp_wd   = wd;
                end
                exp_q.push_back(mk_wb(res, 5'(16 + o), rw, addr + 32'd4));
                drive_in(mk_op(1'b1, res, addr, wd, f3, 1'b1, 5'(16 + o), rw, addr + 32'd4), ok);
                n_checks++;
                if (mem_req_valid !== 1'b1 || mem_req_wen !== 1'b1 ||
                    mem_req_addr !== {addr[31:2], 2'b00} ||
                    mem_req_wstrb !== exp_strb || mem_req_wdata !== exp_wd) begin
                    n_fails++; $display("FAIL st_req f3=%b off=%0d: got addr=%h wstrb=%b wdata=%h expected %h/%b/%h",
                                        f3, o, mem_req_addr, mem_req_wstrb, mem_req_wdata,
                                        {addr[31:2], 2'b00}, exp_strb, exp_wd);
                end
                wait_out(lat);
                e = exp_q.pop_front();
                n_checks++;
                if (!ok || lat != 3 || out_data !== e) begin
                    n_fails++; $display("FAIL st_wb f3=%b off=%0d: got lat=%0d data=%h expected 3/%h",
                                        f3, o, lat, out_data, e);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        int      lat;
        bit      ok;
        lsu_wb_t e;
        mem_rsp_delay = 3;
        mem_word      = 32'h1111_2222;
        drive_in(mk_op(1'b1, 32'h0, 32'h0000_2000, 32'h0, F3_W, 1'b0, 5'd11, 1'b1,
                       32'h0000_0400), ok);
        @(negedge clk);
        n_checks++;
        if (!ok || mem_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fails++; $display("FAIL rst_mid_in_resp: got req=%b out=%b in_ready=%b expected 0/0/0",
                                mem_req_valid, out_valid, in_ready);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++; $display("FAIL rst_mid_idle: got out=%b req=%b in_ready=%b expected 0/0/1",
                                out_valid, mem_req_valid, in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fails++; $display("FAIL stray_rsp_ignored cycle %0d: got out=%b in_ready=%b expected 0/1",
                                    c, out_valid, in_ready);
            end
        end
        mem_rsp_delay = 1;
        exp_q.push_back(mk_wb(32'h0BAD_F00D, 5'd12, 1'b1, 32'h0000_0404));
        drive_in(mk_op(1'b0, 32'h0BAD_F00D, 32'h0, 32'h0, F3_W, 1'b0, 5'd12, 1'b1,
                       32'h0000_0404), ok);
        wait_out(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || lat != 1 || out_data !== e) begin
            n_fails++; $display("FAIL post_reset_pass: got lat=%0d data=%h expected 1/%h",
                                lat, out_data, e);
        end
        @(negedge clk);
    endtask

    task automatic test_align();
        int          lat;
        bit          ok;
        lsu_wb_t     e;
`ifdef LSU_ALIGN_CHECK_EN
        int          seen0;
        seen0 = req_seen;
        exp_q.push_back(mk_wb(32'h0000_0077, 5'd4, 1'b0, 32'h0000_0500));
        drive_in(mk_op(1'b1, 32'h0000_0077, 32'h0000_1002, 32'h0, F3_W, 1'b0, 5'd4, 1'b1,
                       32'h0000_0500), ok);
        wait_out(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || lat != 1 || req_seen != seen0) begin
            n_fails++; $display("FAIL mis_no_req: got lat=%0d req_cycles=%0d expected 1/0",
                                lat, req_seen - seen0);
        end
        n_checks++;
        if (misalign !== 1'b1 || {out_data.rd_addr, out_data.reg_wen, out_data.pc_target} !==
                                 {e.rd_addr, e.reg_wen, e.pc_target}) begin
            n_fails++; $display("FAIL mis_out: got misalign=%b rd=%0d reg_wen=%b pc=%h expected 1/%0d/%b/%h",
                                misalign, out_data.rd_addr, out_data.reg_wen, out_data.pc_target,
                                e.rd_addr, e.reg_wen, e.pc_target);
        end
        @(negedge clk);
        n_checks++;
        if (misalign !== 1'b0) begin
            n_fails++; $display("FAIL mis_clear: got %b expected 0", misalign);
        end
`else
        logic [31:0] word;
        word     = $urandom;
        mem_word = word;
        exp_q.push_back(mk_wb(word, 5'd4, 1'b1, 32'h0000_0500));
        drive_in(mk_op(1'b1, 32'h0000_0077, 32'h0000_1002, 32'h0, F3_W, 1'b0, 5'd4, 1'b1,
                       32'h0000_0500), ok);
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1000) begin
            n_fails++; $display("FAIL lw_trunc_addr: got valid=%b addr=%h expected 1/00001000",
                                mem_req_valid, mem_req_addr);
        end
        wait_out(lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!ok || lat != 3 || out_data !== e) begin
            n_fails++; $display("FAIL lw_trunc_data: got lat=%0d data=%h expected 3/%h",
                                lat, out_data, e);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        n_checks      = 0;
        n_fails       = 0;
        mem_stall     = 0;
        mem_rsp_delay = 1;
        mem_word      = 32'h0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        out_ready     = 1'b1;
        test_reset();
        test_passthrough();
        test_lb_lbu();
        test_store_sh();
        test_back_to_back();
        test_load_matrix();
        test_store_matrix();
        test_reset_mid();
        test_align();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
